agu_hash_seq: RTL and testbench
===============================

Name: agu_hash_seq

Overview:
- Parametrised, sequenced address generator for SHAKE/hash output writes into matrix/vector RAMs (S, S', E', E, B, B').
- Produces a RAM word address plus a sub-word lane index (bias), one step per accepted hash-output beat.
- Adds the following to the single-shot AGU:
  - start/busy/done run control
  - latched mode and level
  - terminal-count detection
  - illegal-configuration flagging
  - generic address, bias and pair widths

Parameters:
- ADDR_W, 12, address width.
- BIAS_W, 3, lane-index width; lanes per word = 2^BIAS_W.
- PAIR_W, 1, log2 of beats per address in paired mode (101); must be < BIAS_W.
- LOOP_L1, 1343, last address index for level 2'b01.
- LOOP_L2, 975, last address index for level 2'b10.
- LOOP_L3, 639, last address index for level 2'b11.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- addr_clr  in  1  synchronous clear of counters and run state.
- start  in  1  begin run; latches mode and level.
- mode  in  3  000 = S/S'/E', 001 = E, 100 = B, 101 = B'.
- level  in  2  parameter-set select; 00 is illegal.
- add_en  in  1  step request (one hash beat consumed).
- addr_output  out  ADDR_W  current address.
- bias  out  BIAS_W  current lane / pair / column index.
- busy  out  1  run active.
- done  out  1  one-cycle pulse on the final step.
- err  out  1  one-cycle pulse when start is given with an illegal mode or level.

Behaviour:
- Reset (rst high, async): addr_output = 0, bias = 0, busy = 0, done = 0, err = 0, mode_q = 0, level_q = 0.
- Priority each cycle: addr_clr > start > add_en.
  - addr_clr: addr_output, bias, busy all go to 0; done and err are 0.
- start:
  - Legal mode and level: latch mode_q/level_q, clear addr_output/bias, busy <= 1 next cycle.
  - Illegal (level 00, or mode not in {000, 001, 100, 101}): busy stays 0, err = 1 for one cycle, counters cleared.
  - start while busy restarts the run; the old run is abandoned and done is not pulsed.
- loop is chosen from level_q: 01 -> LOOP_L1, 10 -> LOOP_L2, 11 -> LOOP_L3. It is zero-extended to ADDR_W.
- add_en is ignored when busy = 0. Each step below updates registers on the add_en edge (zero latency); the outputs are valid the cycle after.
- Mode 000:
  - addr == loop: addr <= 0, bias <= bias + 1.
  - Otherwise: addr <= addr + 1.
  - Terminal: addr == loop and bias == all ones.
- Mode 001:
  - bias == all ones: bias <= 0, addr <= addr + 1.
  - Otherwise: bias <= bias + 1.
  - Terminal: addr == loop and bias == all ones.
- Mode 100:
  - addr <= addr + 1.
  - Terminal: addr == loop.
- Mode 101:
  - Lane field: bias[PAIR_W-1:0] increments every step.
  - When the lane field is all ones:
    - If addr[ADDR_W-1:PAIR_W] == loop: addr <= 0 and bias[BIAS_W-1:PAIR_W] += 1.
    - Otherwise: addr[ADDR_W-1:PAIR_W] += 1.
  - addr[PAIR_W-1:0] is always 0.
  - Terminal: lane all ones, upper address == loop, and upper bias all ones.
- On the terminal step:
  - addr_output and bias go to 0, busy <= 0, done = 1 for exactly one cycle.
  - A further add_en is ignored.
- Wrap arithmetic is modulo field width. The upper address must not exceed ADDR_W-PAIR_W bits; parameters must satisfy that.
- Mode or level inputs changing mid-run have no effect; only mode_q/level_q are used.
- rst asserted mid-run aborts immediately to reset values. The first run after reset requires start.

Decomposition:
- Shared package agu_pkg:
  - mode localparams: MODE_S = 3'b000, MODE_E = 3'b001, MODE_B = 3'b100, MODE_BP = 3'b101
  - level encodings
  - function loop_of(level) returning the LOOP_Lx value
- One sub-module, agu_step_core: combinational next-state and terminal logic (inputs mode_q, addr, bias, loop; outputs addr_nxt, bias_nxt, term).
- The top module holds registers, start/clear priority, busy/done/err.

Test Plan:
- Mode 100, level 11, start then 640 consecutive add_en -> addr steps 0..639, done pulses on the 640th step, busy falls, addr = 0; a 641st add_en leaves addr at 0.
- Mode 000, level 11 -> after 640 steps addr = 0 and bias = 1; after 640 × 8 = 5120 steps done pulses, bias = 0.
- Mode 001, level 01 -> first 8 steps keep addr = 0 with bias 0..7; step 9 gives addr = 1, bias = 0; done after 1344 × 8 steps.
- Mode 101, level 10 -> the step sequence gives (addr, bias) = (0,0), (0,1), (2,0), (2,1), ...; after 2 × 976 steps addr = 0 and bias = 2; done after 2 × 976 × 4 steps.
- start with level 00, or with mode 011 -> err = 1 for one cycle, busy stays 0, add_en has no effect.
- Mid-run add_en, start and addr_clr in the same cycle -> counters 0, busy = 0. Assert rst mid-run -> all outputs 0 asynchronously. start mid-run -> restart from 0 with no done pulse.

Source files
------------

// File: rtl/agu_pkg.sv
// agu_pkg: mode/level encodings and configuration helpers shared by agu_hash_seq
// and agu_step_core (no ports)
package agu_pkg;
   localparam logic [2:0] MODE_S  = 3'b000;
   localparam logic [2:0] MODE_E  = 3'b001;
   localparam logic [2:0] MODE_B  = 3'b100;
   localparam logic [2:0] MODE_BP = 3'b101;
   localparam logic [1:0] LVL_BAD = 2'b00;
   localparam logic [1:0] LVL_1   = 2'b01;
   localparam logic [1:0] LVL_2   = 2'b10;
   localparam logic [1:0] LVL_3   = 2'b11;
   function automatic logic mode_ok(input logic [2:0] m);
      return m == MODE_S || m == MODE_E || m == MODE_B || m == MODE_BP;
   endfunction
   function automatic int unsigned loop_of(input logic [1:0] lvl, input int unsigned l1, l2, l3);
      return lvl == LVL_1 ? l1 : lvl == LVL_2 ? l2 : lvl == LVL_3 ? l3 : 0;
   endfunction
endpackage

// File: rtl/agu_step_core.sv
// agu_step_core: combinational next address/bias and terminal detect for one step
// ports: mode_q, addr, bias, loop in; addr_nxt, bias_nxt, term out
module agu_step_core
   import agu_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int BIAS_W = 3,
   parameter int PAIR_W = 1
) (
   input  logic [2:0]        mode_q,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BIAS_W-1:0] bias,
   input  logic [ADDR_W-1:0] loop,
   output logic [ADDR_W-1:0] addr_nxt,
   output logic [BIAS_W-1:0] bias_nxt,
   output logic              term
);
   localparam int UA_W = ADDR_W - PAIR_W;
   localparam int UB_W = BIAS_W - PAIR_W;
   logic [UA_W-1:0]   ua;
   logic [UB_W-1:0]   ub;
   logic [PAIR_W-1:0] lane;
   logic a_end, b_full, l_full, u_end;
   // paired mode splits addr/bias into an upper counter and a low lane field
   assign ua     = addr[ADDR_W-1:PAIR_W];
   assign ub     = bias[BIAS_W-1:PAIR_W];
   assign lane   = bias[PAIR_W-1:0];
   assign a_end  = addr == loop;
   assign b_full = &bias;
   assign l_full = &lane;
   assign u_end  = ADDR_W'(ua) == loop;
   always_comb begin
      addr_nxt = addr;
      bias_nxt = bias;
      term     = 1'b0;
      case (mode_q)
         MODE_S: begin
            addr_nxt = a_end ? '0 : addr + 1'b1;
            bias_nxt = a_end ? bias + 1'b1 : bias;
            term     = a_end && b_full;
         end
         MODE_E: begin
            addr_nxt = b_full ? addr + 1'b1 : addr;
            bias_nxt = bias + 1'b1;
            term     = a_end && b_full;
         end
         MODE_B: begin
            addr_nxt = addr + 1'b1;
            term     = a_end;
         end
         MODE_BP: begin
            bias_nxt = {(l_full && u_end) ? ub + 1'b1 : ub, lane + 1'b1};
            addr_nxt = !l_full ? addr : u_end ? '0 : {ua + 1'b1, {PAIR_W{1'b0}}};
            term     = l_full && u_end && &ub;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/agu_hash_seq.sv
// agu_hash_seq: sequenced RAM address/lane generator for hash output writes
// ports: clk, rst (async, active-high), addr_clr, start, mode, level, add_en in;
//        addr_output, bias, busy, done, err out
module agu_hash_seq
   import agu_pkg::*;
#(
   parameter int          ADDR_W  = 12,
   parameter int          BIAS_W  = 3,
   parameter int          PAIR_W  = 1,
   parameter int unsigned LOOP_L1 = 1343,
   parameter int unsigned LOOP_L2 = 975,
   parameter int unsigned LOOP_L3 = 639
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              addr_clr,
   input  logic              start,
   input  logic [2:0]        mode,
   input  logic [1:0]        level,
   input  logic              add_en,
   output logic [ADDR_W-1:0] addr_output,
   output logic [BIAS_W-1:0] bias,
   output logic              busy,
   output logic              done,
   output logic              err
);
   logic [2:0]        mode_q;
   logic [1:0]        level_q;
   logic [ADDR_W-1:0] loop, addr_nxt;
   logic [BIAS_W-1:0] bias_nxt;
   logic              term, legal;
   assign loop  = ADDR_W'(loop_of(level_q, LOOP_L1, LOOP_L2, LOOP_L3));
   assign legal = mode_ok(mode) && level != LVL_BAD;
   agu_step_core #(.ADDR_W(ADDR_W), .BIAS_W(BIAS_W), .PAIR_W(PAIR_W)) u_core (
      .mode_q   (mode_q),
      .addr     (addr_output),
      .bias     (bias),
      .loop     (loop),
      .addr_nxt (addr_nxt),
      .bias_nxt (bias_nxt),
      .term     (term)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_output <= '0;
         bias        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         mode_q      <= '0;
         level_q     <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (addr_clr) begin
            addr_output <= '0;
            bias        <= '0;
            busy        <= 1'b0;
         end else if (start) begin
            // a restart abandons any run in progress without a done pulse
            addr_output <= '0;
            bias        <= '0;
            busy        <= legal;
            err         <= !legal;
            if (legal) begin
               mode_q  <= mode;
               level_q <= level;
            end
         end else if (add_en && busy) begin
            addr_output <= term ? '0 : addr_nxt;
            bias        <= term ? '0 : bias_nxt;
            busy        <= !term;
            done        <= term;
         end
      end
   end
endmodule

// File: tb/tb_agu_hash_seq.sv
// tb_agu_hash_seq: randomized self-checking bench against a step-count reference model
module tb_agu_hash_seq;
   logic        clk = 1'b0, rst = 1'b0, addr_clr = 1'b0, start = 1'b0, add_en = 1'b0;
   logic [2:0]  mode = '0;
   logic [1:0]  level = '0;
   logic [11:0] addr_output;
   logic [2:0]  bias;
   logic        busy, done, err;
   int          n_chk = 0, n_pass = 0;
   int          k = 0, m_loop = 0;
   logic [2:0]  m_mode = '0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
   int          loops [4] = '{0, 1343, 975, 639};

   agu_hash_seq dut (
      .clk         (clk),
      .rst         (rst),
      .addr_clr    (addr_clr),
      .start       (start),
      .mode        (mode),
      .level       (level),
      .add_en      (add_en),
      .addr_output (addr_output),
      .bias        (bias),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic int total();
      return m_mode == 3'b100 ? m_loop + 1 : 8 * (m_loop + 1);
   endfunction

   // k counts accepted steps of the current run; the position follows from it arithmetically
   task automatic check_all();
      int ea, eb, n;
      n = m_loop + 1;
      if (m_mode == 3'b000) begin ea = k % n; eb = k / n; end
      else if (m_mode == 3'b001) begin ea = k / 8; eb = k % 8; end
      else if (m_mode == 3'b100) begin ea = k; eb = 0; end
      else begin ea = 2 * ((k / 2) % n); eb = 2 * (k / (2 * n)) + k % 2; end
      check("addr", 32'(addr_output), ea);
      check("bias", 32'(bias), eb);
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
   endtask

   task automatic model(input logic s, c, a, input logic [2:0] md, input logic [1:0] lv);
      logic ok;
      ok = lv != 2'b00 && (md == 3'd0 || md == 3'd1 || md == 3'd4 || md == 3'd5);
      m_done = 1'b0;
      m_err  = 1'b0;
      if (c) begin
         m_busy = 1'b0; k = 0;
      end else if (s) begin
         k = 0;
         m_busy = ok;
         m_err  = !ok;
         if (ok) begin m_mode = md; m_loop = loops[lv]; end
      end else if (a && m_busy) begin
         k++;
         if (k == total()) begin k = 0; m_busy = 1'b0; m_done = 1'b1; end
      end
   endtask

   task automatic cyc(input logic s, c, a, input logic [2:0] md, input logic [1:0] lv);
      start = s; addr_clr = c; add_en = a; mode = md; level = lv;
      @(posedge clk);
      model(s, c, a, md, lv);
      #1 check_all();
   endtask

   task automatic run(input logic [2:0] md, input logic [1:0] lv);
      int budget;
      cyc(1'b1, 1'b0, 1'b0, md, lv);
      budget = 2 * total() + 200;
      while (m_busy && budget > 0) begin
         cyc(1'b0, 1'b0, $urandom_range(0, 15) != 0, 3'($urandom), 2'($urandom));
         budget--;
      end
      cyc(1'b0, 1'b0, 1'b1, md, lv);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 3'($urandom), 2'($urandom));
   endtask

   initial begin
      #1 rst = 1'b1;
      #2 check_all();
      #5 rst = 1'b0;
      steps(3);
      run(3'b100, 2'b11);
      run(3'b000, 2'b11);
      run(3'b001, 2'b01);
      run(3'b101, 2'b10);
      cyc(1'b1, 1'b0, 1'b0, 3'b100, 2'b11);
      steps(5);
      cyc(1'b1, 1'b0, 1'b0, 3'b011, 2'b11);
      steps(3);
      cyc(1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
      steps(3);
      cyc(1'b1, 1'b0, 1'b0, 3'b000, 2'b01);
      steps(20);
      cyc(1'b1, 1'b1, 1'b1, 3'b000, 2'b01);
      steps(3);
      cyc(1'b1, 1'b0, 1'b0, 3'b100, 2'b11);
      steps(630);
      cyc(1'b1, 1'b0, 1'b1, 3'b100, 2'b11);
      steps(641);
      cyc(1'b1, 1'b0, 1'b0, 3'b001, 2'b10);
      steps(50);
      #2 rst = 1'b1;
      #1 begin k = 0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; end
      check_all();
      #1 rst = 1'b0;
      steps(3);
      for (int i = 0; i < 4000; i++) begin
         logic [2:0] md;
         md = $urandom_range(0, 9) == 0 ? 3'($urandom)
            : {$urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1};
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 149) == 0,
             $urandom_range(0, 3) != 0, md, 2'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
